// File: rtl/sync_debounce_bank_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared types and helpers for the sync_debounce_bank input conditioner.
//   edge_e    : per-channel edge report produced by sync_debounce_ch
//   cnt_width : width of a debounce counter able to hold 0..debounce
// -----------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_e;

    // Never narrower than one bit so a counter declaration is always legal.
    function automatic int cnt_width(input int debounce);
        int w;
        w = $clog2(debounce + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_debounce_bank_if.sv
// -----------------------------------------------------------------------------
// sync_debounce_bank_if
// Pin-side and logic-side signals of the debounce bank.
//   async_i   : asynchronous pin inputs                 (master -> slave)
//   sync_o    : synchronised raw value                  (slave -> master)
//   level_o   : debounced level                         (slave -> master)
//   rise_o    : one-cycle 0->1 pulse per channel        (slave -> master)
//   fall_o    : one-cycle 1->0 pulse per channel        (slave -> master)
//   changed_o : any channel pulsed this cycle           (slave -> master)
// The bank itself uses the slave modport.
// -----------------------------------------------------------------------------
interface sync_debounce_bank_if #(
    parameter int CHANNELS = 4
) ();

    logic [CHANNELS-1:0] async_i;
    logic [CHANNELS-1:0] sync_o;
    logic [CHANNELS-1:0] level_o;
    logic [CHANNELS-1:0] rise_o;
    logic [CHANNELS-1:0] fall_o;
    logic                changed_o;

    modport master (
        output async_i,
        input  sync_o, level_o, rise_o, fall_o, changed_o
    );

    modport slave (
        input  async_i,
        output sync_o, level_o, rise_o, fall_o, changed_o
    );

endinterface

// File: rtl/sync_debounce_bank_ch.sv
// -----------------------------------------------------------------------------
// sync_debounce_ch
// One input channel: STAGES-deep synchroniser, optional debounce counter,
// registered debounced level and registered edge report.
//   clk_i        : clock, all state on rising edge
//   rst_i        : synchronous active-high reset
//   i_async      : asynchronous pin input
//   o_sync       : last synchroniser stage
//   o_level      : debounced level
//   o_edge       : EDGE_RISE/EDGE_FALL for the first cycle of a new level
//   o_accept_nxt : high when o_level will change at the coming edge
// -----------------------------------------------------------------------------
module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter int   DEBOUNCE  = 4,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  i_async,
    output logic  o_sync,
    output logic  o_level,
    output edge_e o_edge,
    output logic  o_accept_nxt
);

    localparam int CW = cnt_width(DEBOUNCE);

    logic [STAGES-1:0] r_sync;
    logic              r_level;
    edge_e             r_edge;
    logic              w_sync;
    logic              w_accept;

    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours; blocking here would
    // collapse the synchroniser chain into a single flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign w_sync = r_sync[STAGES-1];

    if (DEBOUNCE > 0) begin : g_filter
        localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

        logic [CW-1:0] r_cnt;

        // Counts consecutive cycles where the synchronised value disagrees
        // with the accepted level; any agreement restarts the count.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt <= '0;
            end else if (w_sync == r_level || w_accept) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign w_accept = (w_sync != r_level) && (r_cnt == LAST);
    end else begin : g_bypass
        // Level simply follows sync one edge later; only a difference
        // produces a pulse.
        assign w_accept = (w_sync != r_level);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_level <= RESET_VAL;
            r_edge  <= EDGE_NONE;
        end else begin
            r_edge <= EDGE_NONE;
            if (w_accept) begin
                r_level <= w_sync;
                r_edge  <= w_sync ? EDGE_RISE : EDGE_FALL;
            end
        end
    end

    assign o_sync       = w_sync;
    assign o_level      = r_level;
    assign o_edge       = r_edge;
    assign o_accept_nxt = w_accept;

endmodule

// File: rtl/sync_debounce_bank.sv
// -----------------------------------------------------------------------------
// sync_debounce_bank
// Multi-channel pin conditioner. Each channel is independent: never use this
// for multi-bit buses or counters, the channels have no mutual coherence.
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of sync_debounce_bank_if
//           (async_i in; sync_o, level_o, rise_o, fall_o, changed_o out)
// Pin-to-level latency is STAGES + max(DEBOUNCE,1) edges.
// -----------------------------------------------------------------------------
module sync_debounce_bank
    import sync_pkg::*;
#(
    parameter int                  CHANNELS  = 4,
    parameter int                  STAGES    = 2,
    parameter int                  DEBOUNCE  = 4,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    sync_debounce_bank_if.slave bus
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_debounce_bank: STAGES must be >= 2");
    end

    edge_e               w_edge [CHANNELS];
    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] w_level;
    logic [CHANNELS-1:0] w_accept;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic                r_changed;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sync_debounce_ch #(
            .STAGES    (STAGES),
            .DEBOUNCE  (DEBOUNCE),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .i_async      (bus.async_i[i]),
            .o_sync       (w_sync[i]),
            .o_level      (w_level[i]),
            .o_edge       (w_edge[i]),
            .o_accept_nxt (w_accept[i])
        );
    end

    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_rise = '0;
        w_fall = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_rise[i] = (w_edge[i] == EDGE_RISE);
            w_fall[i] = (w_edge[i] == EDGE_FALL);
        end
    end

    // Registered from the channels' accept strobes so it rises in the same
    // edge as the rise/fall pulses it summarises.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_accept;
        end
    end

    assign bus.sync_o    = w_sync;
    assign bus.level_o   = w_level;
    assign bus.rise_o    = w_rise;
    assign bus.fall_o    = w_fall;
    assign bus.changed_o = r_changed;

endmodule

// File: tb/tb_sync_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_sync_debounce_bank
// Directed bench for sync_debounce_bank. u_dut uses the default build
// (4 channels, 2 stages, debounce 4); u_byp uses STAGES=3, DEBOUNCE=0.
// Inputs change and outputs are sampled on the falling clock edge; the edge
// numbers below count rising edges after the stimulus was applied.
// -----------------------------------------------------------------------------
module tb_sync_debounce_bank;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    sync_debounce_bank_if #(.CHANNELS(4)) bus_a ();
    sync_debounce_bank_if #(.CHANNELS(4)) bus_b ();

    sync_debounce_bank #(
        .CHANNELS  (4),
        .STAGES    (2),
        .DEBOUNCE  (4),
        .RESET_VAL (4'h0)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    sync_debounce_bank #(
        .CHANNELS  (4),
        .STAGES    (3),
        .DEBOUNCE  (0),
        .RESET_VAL (4'h0)
    ) u_byp (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [3:0] a);
        bus_a.async_i = a;
        bus_b.async_i = 4'h0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Bypass stimulus: async_i[0] before edge k is 1 for odd k, 0 before start.
    function automatic logic byp_in(input int k);
        return (k >= 1) ? k[0] : 1'b0;
    endfunction

    initial begin
        logic b_seq [8];
        int   n_rise;
        logic b_val;
        logic prev_val;

        b_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

        // ---- Reset with all pins high: outputs stay 0 during reset ----
        rst           = 1'b1;
        bus_a.async_i = 4'hF;
        bus_b.async_i = 4'h0;
        @(negedge clk);
        for (int e = 1; e <= 3; e++) begin
            step();
            check($sformatf("rst_sync_e%0d", e),    bus_a.sync_o,    4'h0);
            check($sformatf("rst_level_e%0d", e),   bus_a.level_o,   4'h0);
            check($sformatf("rst_pulse_e%0d", e),   {bus_a.rise_o, bus_a.fall_o}, 8'h00);
            check($sformatf("rst_changed_e%0d", e), bus_a.changed_o, 1'b0);
        end
        rst = 1'b0;

        // ---- Release: sync at edge 2, level/rise at edge 6, rise gone at 7 ----
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("rel_sync_e%0d", e),    bus_a.sync_o,    (e >= 2) ? 4'hF : 4'h0);
            check($sformatf("rel_level_e%0d", e),   bus_a.level_o,   (e >= 6) ? 4'hF : 4'h0);
            check($sformatf("rel_rise_e%0d", e),    bus_a.rise_o,    (e == 6) ? 4'hF : 4'h0);
            check($sformatf("rel_fall_e%0d", e),    bus_a.fall_o,    4'h0);
            check($sformatf("rel_changed_e%0d", e), bus_a.changed_o, (e == 6));
        end

        // ---- Glitch: ch1 high for 3 cycles is filtered ----
        do_reset(4'h0);
        bus_a.async_i[1] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            if (e == 4) bus_a.async_i[1] = 1'b0;
            step();
            check($sformatf("gl_sync1_e%0d", e),  bus_a.sync_o[1],  (e >= 2 && e <= 4));
            check($sformatf("gl_level1_e%0d", e), bus_a.level_o[1], 1'b0);
            check($sformatf("gl_rise1_e%0d", e),  bus_a.rise_o[1],  1'b0);
        end

        // ---- Held high: rise at edge STAGES+4 = 6 ----
        bus_a.async_i[1] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("hold_level1_e%0d", e), bus_a.level_o[1], (e >= 6));
            check($sformatf("hold_rise1_e%0d", e),  bus_a.rise_o[1],  (e == 6));
        end

        // ---- Bounce on ch0: 1,0,1,0,1,1,1,1 -> single rise at edge 10 ----
        n_rise   = 0;
        prev_val = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            b_val            = (e <= 8) ? b_seq[e-1] : 1'b1;
            bus_a.async_i[0] = b_val;
            step();
            if (bus_a.rise_o[0] === 1'b1) n_rise++;
            check($sformatf("bnc_sync0_e%0d", e), bus_a.sync_o[0], (e >= 2) ? prev_val : 1'b0);
            check($sformatf("bnc_rise0_e%0d", e), bus_a.rise_o[0], (e == 10));
            // sync after edge e+1 equals the input applied before edge e
            prev_val = b_val;
        end
        check("bnc_rise_count", n_rise, 1);

        // ---- Simultaneous: ch0 0->1 and ch2 1->0 pulse together ----
        do_reset(4'h0);
        bus_a.async_i = 4'b0100;
        repeat (8) step();
        check("sim_pre_level", bus_a.level_o, 4'b0100);
        bus_a.async_i = 4'b0001;
        for (int e = 1; e <= 8; e++) begin
            step();
            check($sformatf("sim_rise_e%0d", e),    bus_a.rise_o,    (e == 6) ? 4'b0001 : 4'b0000);
            check($sformatf("sim_fall_e%0d", e),    bus_a.fall_o,    (e == 6) ? 4'b0100 : 4'b0000);
            check($sformatf("sim_changed_e%0d", e), bus_a.changed_o, (e == 6));
            check($sformatf("sim_level_e%0d", e),   bus_a.level_o,   (e >= 6) ? 4'b0001 : 4'b0100);
        end

        // ---- Reset mid-count on ch3 (counter at 2 after edge 4) ----
        do_reset(4'h0);
        bus_a.async_i = 4'b1000;
        repeat (4) step();
        check("mid_pre_level3", bus_a.level_o[3], 1'b0);
        rst = 1'b1;
        step();
        check("mid_rst_sync",    bus_a.sync_o,    4'h0);
        check("mid_rst_level",   bus_a.level_o,   4'h0);
        check("mid_rst_rise",    bus_a.rise_o,    4'h0);
        check("mid_rst_changed", bus_a.changed_o, 1'b0);
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("mid_level3_e%0d", e), bus_a.level_o[3], (e >= 6));
            check($sformatf("mid_rise3_e%0d", e),  bus_a.rise_o[3],  (e == 6));
        end

        // ---- Bypass build: level follows sync one edge later ----
        do_reset(4'h0);
        for (int e = 1; e <= 12; e++) begin
            bus_b.async_i[0] = byp_in(e);
            step();
            check($sformatf("byp_sync_e%0d", e),  bus_b.sync_o[0],  byp_in(e - 2));
            check($sformatf("byp_level_e%0d", e), bus_b.level_o[0], byp_in(e - 3));
            check($sformatf("byp_rise_e%0d", e),  bus_b.rise_o[0],  byp_in(e - 3) & ~byp_in(e - 4));
            check($sformatf("byp_fall_e%0d", e),  bus_b.fall_o[0],  ~byp_in(e - 3) & byp_in(e - 4));
            check($sformatf("byp_changed_e%0d", e), bus_b.changed_o, (e >= 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
